// File: rtl/instr_mem_responder.sv
// Instruction-fetch slave: grants requests, reads a word array and returns in-order data after LATENCY cycles.
// Outstanding requests are bounded; a side load port preloads images, and stall_i holds off grants.
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         instr_req_i,
  output logic                         instr_gnt_o,
  input  logic [31:0]                  instr_addr_i,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  output logic                         instr_rvalid_o,
  input  logic                         stall_i,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [31:0]        mem_q [MEM_WORDS];

  logic [31:0]        offset;
  logic [AW-1:0]      word_idx;
  logic               addr_err;
  logic               accept;
  logic               retire;

  logic [CW-1:0]      outst_q, outst_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    offset   = instr_addr_i - BASE_ADDR;
    word_idx = offset[AW+1:2];
    addr_err = (offset >> (AW + 2)) != 32'h0;
  end

  always_comb begin
    retire      = vld_q[LATENCY-1];
    instr_gnt_o = instr_req_i & ~stall_i & ((outst_q < MAX_CNT) | retire);
    accept      = instr_req_i & instr_gnt_o;

    outst_d = outst_q;
    case ({accept, retire})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  // Stage 0 captures the array read taken in the accept cycle; empty or errored slots carry zero data.
  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    dat_d[0] = 32'h0;
    vld_d[0] = accept;
    err_d[0] = accept & addr_err;
    if (accept && !addr_err) begin
      dat_d[0] = mem_q[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_q <= '0;
      vld_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= 32'h0;
      end
    end else begin
      outst_q <= outst_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Array is intentionally unreset; a same-cycle fetch sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  assign instr_rvalid_o = vld_q[LATENCY-1];
  assign instr_err_o    = err_q[LATENCY-1];
  assign instr_rdata_o  = dat_q[LATENCY-1];

endmodule
